// File: rtl/regfile_scoreboard_if.sv
// Register-file/scoreboard bus: read ports, writeback, reservation and status.
// master drives requests; slave is the register file.
interface regfile_scoreboard_if #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int NRD  = 3
);
   localparam int AW = $clog2(NREG);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic                rsv_ok;
   logic                flush;
   logic [XLEN-1:0]     sp;
   logic [AW:0]         busy_cnt;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
      input  rd_data, rd_busy, rsv_ok, sp, busy_cnt
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
      output rd_data, rd_busy, rsv_ok, sp, busy_cnt
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register busy scoreboard and reservation.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard #(
   parameter int XLEN    = 64,
   parameter int NREG    = 32,
   parameter int NRD     = 3,
   parameter int SP_IDX  = NREG - 1,
   parameter int R0_ZERO = 1
) (
   input  logic clk,
   input  logic reset,
   regfile_scoreboard_if.slave bus
);
   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0]     regs [NREG];
   logic [NREG-1:0]     busy_reg;
   logic [NREG-1:0]     busy_next;
   logic [AW:0]         busy_cnt_reg;
   logic [AW:0]         busy_cnt_next;
   logic                rsv_is_r0;
   logic                wr_is_r0;
   logic                rsv_ok;
   logic [NRD*XLEN-1:0] rd_data_all;
   logic [NRD-1:0]      rd_busy_all;

   always_comb begin
      rsv_is_r0 = (R0_ZERO != 0) && (bus.rsv_addr == '0);
      wr_is_r0  = (R0_ZERO != 0) && (bus.wr_addr == '0);
      rsv_ok    = 1'b0;
      // A writeback retiring the same register frees it in time for the new owner
      if (bus.rsv_en && !bus.flush && !reset)
         rsv_ok = rsv_is_r0 || !busy_reg[bus.rsv_addr]
                  || (bus.wr_en && (bus.wr_addr == bus.rsv_addr));
   end

   always_comb begin
      busy_next = busy_reg;
      if (bus.wr_en)
         busy_next[bus.wr_addr] = 1'b0;
      if (rsv_ok && !rsv_is_r0)
         busy_next[bus.rsv_addr] = 1'b1;
      if (bus.flush)
         busy_next = '0;
      if (R0_ZERO != 0)
         busy_next[0] = 1'b0;
      busy_cnt_next = '0;
      for (int i = 0; i < NREG; i++)
         busy_cnt_next = busy_cnt_next + (AW+1)'(busy_next[i]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_reg     <= '0;
         busy_cnt_reg <= '0;
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else begin
         busy_reg     <= busy_next;
         busy_cnt_reg <= busy_cnt_next;
         if (bus.wr_en && !wr_is_r0)
            regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]   addr;
         logic [XLEN-1:0] data;
         logic            bsy;

         assign addr = bus.rd_addr[gi*AW +: AW];

         always_comb begin
            data = regs[addr];
            bsy  = busy_reg[addr];
`ifdef REGFILE_BYPASS_EN
            if (bus.wr_en && (bus.wr_addr == addr) && !((R0_ZERO != 0) && (addr == '0))) begin
               data = bus.wr_data;
               bsy  = 1'b0;
            end
`endif
            // Forwarded data must not leak out while reset is held
            if (reset || ((R0_ZERO != 0) && (addr == '0))) begin
               data = '0;
               bsy  = 1'b0;
            end
         end

         assign rd_data_all[gi*XLEN +: XLEN] = data;
         assign rd_busy_all[gi]              = bsy;
      end
   endgenerate

   assign bus.rd_data  = rd_data_all;
   assign bus.rd_busy  = rd_busy_all;
   assign bus.rsv_ok   = rsv_ok;
   assign bus.sp       = reset ? '0 : regs[SP_IDX];
   assign bus.busy_cnt = busy_cnt_reg;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed + randomised bench for regfile_scoreboard using an expected-value queue.
module tb_regfile_scoreboard;
   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int NRD  = 3;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

   regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q [$];
   string       tag_q [$];

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic expect_val(input string tag, input logic [63:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic observe(input logic [63:0] got);
      string       t;
      logic [63:0] e;
      if (exp_q.size() == 0) begin
         check_value("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         $display("txn %-16s got=%h exp=%h", t, got, e);
         check_value(t, got, e);
      end
   endtask

   function automatic logic [63:0] rdp(input int p);
      return bus.rd_data[p*XLEN +: XLEN];
   endfunction

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      bus.rd_addr[p*AW +: AW] = a;
   endtask

   task automatic idle();
      bus.rd_addr  = '0;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.rsv_en   = 1'b0;
      bus.rsv_addr = '0;
      bus.flush    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [63:0]   d;
      int            p;

      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      // reset state, with a live reservation request that must be refused
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3; set_rd(0, 5'd5);
      expect_val("rst_rd0", 0); expect_val("rst_busy", 0); expect_val("rst_sp", 0);
      expect_val("rst_rsv_ok", 0); expect_val("rst_busy_cnt", 0);
      @(negedge clk);
      observe(rdp(0)); observe(64'(bus.rd_busy)); observe(bus.sp);
      observe(64'(bus.rsv_ok)); observe(64'(bus.busy_cnt));

      tick(); reset = 1'b0; idle();
      // write reg5, read it back next cycle
      bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 64'hDEAD_BEEF;
      tick(); idle(); set_rd(0, 5'd5);
      expect_val("r5_read", 64'hDEAD_BEEF); expect_val("r5_sp", 0);
      @(negedge clk);
      observe(rdp(0)); observe(bus.sp);

      // register 0 is hardwired: write ignored, reservation always accepted, never busy
      tick(); idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 64'h1234;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
      expect_val("r0_rsv_ok", 1);
      @(negedge clk);
      observe(64'(bus.rsv_ok));
      tick(); idle();
      for (int i = 0; i < NRD; i++) expect_val("r0_read", 0);
      expect_val("r0_rd_busy", 0); expect_val("r0_busy_cnt", 0);
      @(negedge clk);
      for (int i = 0; i < NRD; i++) observe(rdp(i));
      observe(64'(bus.rd_busy)); observe(64'(bus.busy_cnt));

      // reserve reg7, then re-reserve (refused), then writeback+reserve same cycle
      tick(); idle();
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
      expect_val("r7_rsv1_ok", 1);
      @(negedge clk);
      observe(64'(bus.rsv_ok));
      tick(); idle();
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7; set_rd(0, 5'd7);
      expect_val("r7_rsv2_ok", 0); expect_val("r7_rd_busy", 1); expect_val("r7_busy_cnt", 1);
      @(negedge clk);
      observe(64'(bus.rsv_ok)); observe(64'(bus.rd_busy[0])); observe(64'(bus.busy_cnt));
      tick(); idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h55;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
      expect_val("r7_wb_rsv_ok", 1);
      @(negedge clk);
      observe(64'(bus.rsv_ok));
      tick(); idle(); set_rd(0, 5'd7);
      expect_val("r7_data", 64'h55); expect_val("r7_still_busy", 1); expect_val("r7_cnt", 1);
      @(negedge clk);
      observe(rdp(0)); observe(64'(bus.rd_busy[0])); observe(64'(bus.busy_cnt));

      // same-cycle write and read of a reserved register on two ports
      tick(); idle();
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
      tick(); idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'hA5A5;
      set_rd(0, 5'd3); set_rd(1, 5'd3);
`ifdef REGFILE_BYPASS_EN
      expect_val("byp_rd0", 64'hA5A5); expect_val("byp_rd1", 64'hA5A5);
      expect_val("byp_busy0", 0); expect_val("byp_busy1", 0);
`else
      expect_val("nobyp_rd0", 0); expect_val("nobyp_rd1", 0);
      expect_val("nobyp_busy0", 1); expect_val("nobyp_busy1", 1);
`endif
      @(negedge clk);
      observe(rdp(0)); observe(rdp(1));
      observe(64'(bus.rd_busy[0])); observe(64'(bus.rd_busy[1]));
      tick(); idle(); set_rd(0, 5'd3);
      expect_val("r3_after", 64'hA5A5); expect_val("r3_busy_after", 0); expect_val("cnt_after_r3", 1);
      @(negedge clk);
      observe(rdp(0)); observe(64'(bus.rd_busy[0])); observe(64'(bus.busy_cnt));

      // reserve 1,2,3 then flush with a concurrent reservation and SP write
      for (int r = 1; r <= 3; r++) begin
         tick(); idle();
         bus.rsv_en = 1'b1; bus.rsv_addr = AW'(r);
      end
      tick(); idle();
      expect_val("cnt_before_flush", 4);
      @(negedge clk);
      observe(64'(bus.busy_cnt));
      tick(); idle();
      bus.flush = 1'b1; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = 64'h100;
      expect_val("flush_rsv_ok", 0);
      @(negedge clk);
      observe(64'(bus.rsv_ok));
      tick(); idle(); set_rd(0, 5'd4); set_rd(1, 5'd7);
      expect_val("flush_cnt", 0); expect_val("flush_busy", 0); expect_val("sp_written", 64'h100);
      @(negedge clk);
      observe(64'(bus.busy_cnt)); observe(64'(bus.rd_busy)); observe(bus.sp);

      // random writes read back on rotating ports
      for (int n = 0; n < 16; n++) begin
         tick(); idle();
         a = AW'($urandom_range(1, NREG - 1));
         d = {$urandom, $urandom};
         p = n % NRD;
         bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
         tick(); idle(); set_rd(p, a);
         expect_val("rand_rw", d);
         @(negedge clk);
         observe(rdp(p));
      end

      // reservation outstanding, then reset asserted mid-write
      tick(); idle();
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd10;
      tick(); idle();
      expect_val("cnt_pre_reset", 1);
      @(negedge clk);
      observe(64'(bus.busy_cnt));
      tick(); idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 64'hFFFF;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
      set_rd(0, 5'd9); set_rd(1, 5'd10);
      reset = 1'b1;
      #1;
      expect_val("mid_rst_rd0", 0); expect_val("mid_rst_busy", 0); expect_val("mid_rst_sp", 0);
      expect_val("mid_rst_rsv_ok", 0); expect_val("mid_rst_cnt", 0);
      observe(rdp(0)); observe(64'(bus.rd_busy)); observe(bus.sp);
      observe(64'(bus.rsv_ok)); observe(64'(bus.busy_cnt));
      tick(); reset = 1'b0; idle(); set_rd(0, 5'd9); set_rd(1, 5'd10); set_rd(2, 5'd5);
      expect_val("post_rst_r9", 0); expect_val("post_rst_r5", 0);
      expect_val("post_rst_busy", 0); expect_val("post_rst_cnt", 0);
      @(negedge clk);
      observe(rdp(0)); observe(rdp(2)); observe(64'(bus.rd_busy)); observe(64'(bus.busy_cnt));

      check_value("scoreboard_drain", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL provide parameter XLEN, default 64, register width in bits.
REQ-002 SHALL provide parameter NREG, default 32, register count (power of two, >=2); AW = $clog2(NREG).
REQ-003 SHALL provide parameter NRD, default 3, number of independent read ports.
REQ-004 SHALL provide parameter SP_IDX, default NREG-1, index mirrored on sp.
REQ-005 SHALL provide parameter R0_ZERO, default 1, 1 = register 0 hardwired to zero.
REQ-006 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port rd_addr  input  NRD*AW  packed read addresses, port i at [i*AW +: AW].
REQ-009 SHALL have port rd_data  output  NRD*XLEN  packed read data, port i at [i*XLEN +: XLEN].
REQ-010 SHALL have port rd_busy  output  NRD  port i source has a pending (reserved) write.
REQ-011 SHALL have port wr_en  input  1  writeback strobe.
REQ-012 SHALL have port wr_addr  input  AW  writeback destination.
REQ-013 SHALL have port wr_data  input  XLEN  writeback value.
REQ-014 SHALL have port rsv_en  input  1  issue request to reserve a destination.
REQ-015 SHALL have port rsv_addr  input  AW  destination to reserve.
REQ-016 SHALL have port rsv_ok  output  1  reservation accepted this cycle.
REQ-017 SHALL have port flush  input  1  clear all busy bits (pipeline squash).
REQ-018 SHALL have port sp  output  XLEN  current value of register SP_IDX.
REQ-019 SHALL have port busy_cnt  output  AW+1  number of busy registers.

Function
REQ-020 Reads SHALL be combinational, zero latency: rd_data[i] = reg[rd_addr[i]].
REQ-021 Write with wr_en=1 SHALL update reg[wr_addr] at the rising edge; visible on rd_data next cycle.
REQ-022 With R0_ZERO=1, writes to address 0 SHALL be ignored, reads of 0 SHALL return 0, and reg 0 SHALL never be busy.
REQ-023 Busy bit per register; rsv_en & rsv_ok SHALL set busy[rsv_addr] at the edge.
REQ-024 wr_en SHALL clear busy[wr_addr] at the edge.
REQ-025 rsv_ok SHALL be !busy[rsv_addr] OR (wr_en AND wr_addr==rsv_addr); rsv_ok=0 when rsv_en=0.
REQ-026 With R0_ZERO=1 and rsv_addr=0, rsv_ok SHALL be 1 and no busy bit SHALL be set.
REQ-027 Simultaneous wr_en and accepted reservation to the same address: data written, busy SHALL remain set (reserve wins).
REQ-028 flush SHALL clear every busy bit at the edge and suppress any same-cycle reservation (rsv_ok=0); the register write still occurs.
REQ-029 rd_busy[i] SHALL equal busy[rd_addr[i]], subject to REQ-038.
REQ-030 busy_cnt SHALL equal the population count of busy bits, registered, consistent with busy state after each edge.
REQ-031 sp SHALL equal reg[SP_IDX] combinationally (no bypass applied).
REQ-032 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-033 reset SHALL asynchronously clear all registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-034 During reset rd_data SHALL read 0, rd_busy 0, sp 0, rsv_ok 0.
REQ-035 Reset asserted mid-operation SHALL discard any same-cycle write or reservation.
REQ-036 Reset deassertion SHALL be synchronised externally; the block adds no reset delay.

Configuration
REQ-037 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-038 Defined: when wr_en and wr_addr==rd_addr[i] (and not R0 with R0_ZERO=1), rd_data[i] SHALL be wr_data and rd_busy[i] SHALL be 0 in that same cycle.
REQ-039 Undefined: rd_data[i] SHALL show the pre-write value and rd_busy[i] the stored busy bit; no forwarding logic present.

Verification
REQ-040 Reset, then write reg5=0xDEAD_BEEF, read port 0 addr 5 next cycle -> rd_data=0xDEADBEEF, sp=0.
REQ-041 Write reg0=0x1234 with R0_ZERO=1, read addr 0 on all ports -> 0; rsv_addr=0 -> rsv_ok=1, busy_cnt=0.
REQ-042 Reserve reg7, re-reserve reg7 -> rsv_ok=0, rd_busy=1, busy_cnt=1; writeback reg7=0x55 and reserve reg7 same cycle -> rsv_ok=1, busy stays 1, data 0x55.
REQ-043 Bypass build: wr_en reg3=0xA5A5, read addr 3 same cycle -> rd_data=0xA5A5, rd_busy=0; non-bypass build -> old value, rd_busy=1 if reserved.
REQ-044 Reserve reg1,2,3 then flush with concurrent rsv reg4 -> busy_cnt=0, rsv_ok=0; write reg31=0x100 -> sp=0x100; assert reset mid-write -> all outputs 0 immediately.
